// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch resolve queue: entry payload and saturating increment.
package bp_pkg;

  localparam int unsigned K         = 4;
  localparam int unsigned M         = 3;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;

  typedef struct packed {
    logic [K-1:0] index;
    logic [M-1:0] bhr;
    logic         taken;
  } bp_entry_t;

  // Increment that sticks at max_v; callers narrow the result to their counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Predictor/execute/update bus of the branch resolve queue; slave is the queue, master drives it.
interface branch_resolve_queue_if #(
  parameter int unsigned DEPTH = bp_pkg::DEPTH_DEF,
  parameter int unsigned CNT_W = bp_pkg::CNT_W_DEF
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic                  pred_valid;
  logic                  pred_ready;
  logic [bp_pkg::K-1:0]  pred_index;
  logic [bp_pkg::M-1:0]  pred_bhr;
  logic                  pred_taken;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_outcome;
  logic                  flush;
  logic                  upd_valid;
  logic [bp_pkg::K-1:0]  upd_index;
  logic [bp_pkg::M-1:0]  upd_bhr;
  logic                  upd_outcome;
  logic                  upd_mispredict;
  logic [OCC_W-1:0]      occupancy;
  logic [CNT_W-1:0]      total_cnt;
  logic [CNT_W-1:0]      miss_cnt;

  modport master (
    output pred_valid, pred_index, pred_bhr, pred_taken,
    output res_valid, res_outcome, flush,
    input  pred_ready, res_ready,
    input  upd_valid, upd_index, upd_bhr, upd_outcome, upd_mispredict,
    input  occupancy, total_cnt, miss_cnt
  );

  modport slave (
    input  pred_valid, pred_index, pred_bhr, pred_taken,
    input  res_valid, res_outcome, flush,
    output pred_ready, res_ready,
    output upd_valid, upd_index, upd_bhr, upd_outcome, upd_mispredict,
    output occupancy, total_cnt, miss_cnt
  );

endinterface

// File: rtl/bp_inflight_fifo.sv
// In-flight prediction storage: circular buffer with wrap-bit pointers, push/pop/clear.
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  bp_entry_t                    wdata_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output bp_entry_t                    rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  bp_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            push_ok, pop_ok;

  // Same slot, different lap means full; identical pointers means empty.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = CW'(wr_ptr_q - rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A clear drops any same-cycle push; a same-cycle pop has already read its head.
  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset; pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: pairs issued predictions with execute outcomes, trains the predictor, counts accuracy.
// Optional macro FLUSH_ON_MISS_EN: a resolved mispredict also discards the younger wrong-path entries.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_queue_if.slave bus
);

  localparam int unsigned      OCC_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bp_entry_t        pred_entry;
  bp_entry_t        head;
  logic             full, empty;
  logic             pop, mispredict, flush_eff;
  logic [OCC_W-1:0] count;

  logic             upd_valid_q, upd_valid_d;
  logic [K-1:0]     upd_index_q, upd_index_d;
  logic [M-1:0]     upd_bhr_q, upd_bhr_d;
  logic             upd_outcome_q, upd_outcome_d;
  logic             upd_miss_q, upd_miss_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  assign pred_entry = '{index: bus.pred_index, bhr: bus.pred_bhr, taken: bus.pred_taken};

  bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.pred_valid),
    .wdata_i (pred_entry),
    .pop_i   (bus.res_valid),
    .clear_i (flush_eff),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign pop        = bus.res_valid && !empty;
  assign mispredict = head.taken != bus.res_outcome;

`ifdef FLUSH_ON_MISS_EN
  assign flush_eff = bus.flush || (pop && mispredict);
`else
  assign flush_eff = bus.flush;
`endif

  // Update payload is captured only on a pop and otherwise holds its last value.
  always_comb begin
    upd_valid_d   = pop;
    upd_index_d   = upd_index_q;
    upd_bhr_d     = upd_bhr_q;
    upd_outcome_d = upd_outcome_q;
    upd_miss_d    = upd_miss_q;
    total_d       = total_q;
    miss_d        = miss_q;
    if (pop) begin
      upd_index_d   = head.index;
      upd_bhr_d     = head.bhr;
      upd_outcome_d = bus.res_outcome;
      upd_miss_d    = mispredict;
      total_d       = CNT_W'(sat_inc(32'(total_q), 32'(CNT_MAX)));
      if (mispredict) miss_d = CNT_W'(sat_inc(32'(miss_q), 32'(CNT_MAX)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_valid_q   <= 1'b0;
      upd_index_q   <= '0;
      upd_bhr_q     <= '0;
      upd_outcome_q <= 1'b0;
      upd_miss_q    <= 1'b0;
      total_q       <= '0;
      miss_q        <= '0;
    end else begin
      upd_valid_q   <= upd_valid_d;
      upd_index_q   <= upd_index_d;
      upd_bhr_q     <= upd_bhr_d;
      upd_outcome_q <= upd_outcome_d;
      upd_miss_q    <= upd_miss_d;
      total_q       <= total_d;
      miss_q        <= miss_d;
    end
  end

  assign bus.pred_ready     = !full;
  assign bus.res_ready      = !empty;
  assign bus.occupancy      = count;
  assign bus.upd_valid      = upd_valid_q;
  assign bus.upd_index      = upd_index_q;
  assign bus.upd_bhr        = upd_bhr_q;
  assign bus.upd_outcome    = upd_outcome_q;
  assign bus.upd_mispredict = upd_miss_q;
  assign bus.total_cnt      = total_q;
  assign bus.miss_cnt       = miss_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: queue-based reference model, a 16-bit-counter DUT and a 3-bit-counter twin.
module tb_branch_resolve_queue;
  import bp_pkg::*;

  localparam int unsigned TB_DEPTH  = 4;
  localparam int          SMALL_MAX = 7;

  logic clk;
  logic reset;

  branch_resolve_queue_if #(.DEPTH(TB_DEPTH), .CNT_W(16)) bi ();
  branch_resolve_queue_if #(.DEPTH(TB_DEPTH), .CNT_W(3))  bs ();

  branch_resolve_queue #(.DEPTH(TB_DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bi)
  );
  branch_resolve_queue #(.DEPTH(TB_DEPTH), .CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .bus(bs)
  );

  // The narrow-counter twin sees exactly the same traffic.
  assign bs.pred_valid  = bi.pred_valid;
  assign bs.pred_index  = bi.pred_index;
  assign bs.pred_bhr    = bi.pred_bhr;
  assign bs.pred_taken  = bi.pred_taken;
  assign bs.res_valid   = bi.res_valid;
  assign bs.res_outcome = bi.res_outcome;
  assign bs.flush       = bi.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bp_entry_t    mq[$];
  int           tot, mis;
  logic         exp_uv, exp_uo, exp_um;
  logic [K-1:0] exp_ui;
  logic [M-1:0] exp_ub;
  int           cmp_cnt, bad_cnt;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_reset();
    mq.delete();
    tot = 0; mis = 0;
    exp_uv = 1'b0; exp_uo = 1'b0; exp_um = 1'b0;
    exp_ui = '0; exp_ub = '0;
  endfunction

  task automatic drive_idle();
    bi.pred_valid = 1'b0; bi.pred_index = '0; bi.pred_bhr = '0; bi.pred_taken = 1'b0;
    bi.res_valid = 1'b0; bi.res_outcome = 1'b0; bi.flush = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the reference model across the edge, settle after it.
  task automatic step(input bit pv, input logic [K-1:0] idx, input logic [M-1:0] bhr, input bit tk,
                      input bit rv, input bit oc, input bit fl);
    bit do_push, do_pop, miss, clr;
    bp_entry_t e;
    bi.pred_valid = pv; bi.pred_index = idx; bi.pred_bhr = bhr; bi.pred_taken = tk;
    bi.res_valid = rv; bi.res_outcome = oc; bi.flush = fl;
    do_push = pv && (mq.size() < TB_DEPTH);
    do_pop  = rv && (mq.size() > 0);
    miss    = 1'b0;
    exp_uv  = 1'b0;
    if (do_pop) begin
      e = mq.pop_front();
      miss = (e.taken != oc);
      exp_uv = 1'b1; exp_ui = e.index; exp_ub = e.bhr; exp_uo = oc; exp_um = miss;
      tot++;
      if (miss) mis++;
    end
    clr = fl;
`ifdef FLUSH_ON_MISS_EN
    if (do_pop && miss) clr = 1'b1;
`endif
    if (clr) mq.delete();
    else if (do_push) mq.push_back('{index: idx, bhr: bhr, taken: tk});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      bi.pred_valid = 1'($urandom); bi.pred_index = K'($urandom); bi.pred_bhr = M'($urandom);
      bi.pred_taken = 1'($urandom); bi.res_valid = 1'($urandom); bi.res_outcome = 1'($urandom);
      bi.flush = 1'($urandom);
      @(posedge clk); #1;
      cmp_cnt++; if (bi.occupancy !== 3'd0) begin bad_cnt++; $display("FAIL reset_occ got=%0d exp=0", bi.occupancy); end
      cmp_cnt++; if (bi.upd_valid !== 1'b0) begin bad_cnt++; $display("FAIL reset_upd_valid got=%b exp=0", bi.upd_valid); end
      cmp_cnt++; if ({bi.total_cnt, bi.miss_cnt} !== 32'd0) begin bad_cnt++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bi.total_cnt, bi.miss_cnt); end
      cmp_cnt++; if ({bi.pred_ready, bi.res_ready} !== 2'b10) begin bad_cnt++; $display("FAIL reset_ready got=%b%b exp=10", bi.pred_ready, bi.res_ready); end
      cmp_cnt++; if ({bi.upd_index, bi.upd_bhr} !== 7'd0) begin bad_cnt++; $display("FAIL reset_upd_data got=%h/%h exp=0/0", bi.upd_index, bi.upd_bhr); end
    end
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    step(1'b1, 4'd3, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp_cnt++; if (bi.upd_valid !== 1'b0 || bi.res_ready !== 1'b1) begin bad_cnt++; $display("FAIL single_push got uv=%b rr=%b exp uv=0 rr=1", bi.upd_valid, bi.res_ready); end
    step(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cmp_cnt++; if ({bi.upd_valid, bi.upd_index, bi.upd_bhr, bi.upd_outcome, bi.upd_mispredict} !== {1'b1, 4'd3, 3'd5, 1'b1, 1'b0})
      begin bad_cnt++; $display("FAIL single_upd got v=%b i=%0d b=%0d o=%b m=%b exp v=1 i=3 b=5 o=1 m=0", bi.upd_valid, bi.upd_index, bi.upd_bhr, bi.upd_outcome, bi.upd_mispredict); end
    cmp_cnt++; if (bi.total_cnt !== 16'd1 || bi.miss_cnt !== 16'd0) begin bad_cnt++; $display("FAIL single_cnt got=%0d/%0d exp=1/0", bi.total_cnt, bi.miss_cnt); end
    step(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp_cnt++; if (bi.upd_valid !== 1'b0 || bi.upd_index !== 4'd3 || bi.upd_bhr !== 3'd5) begin bad_cnt++; $display("FAIL single_hold got v=%b i=%0d b=%0d exp v=0 i=3 b=5", bi.upd_valid, bi.upd_index, bi.upd_bhr); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) step(1'b1, K'($urandom), M'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
    cmp_cnt++; if (bi.pred_ready !== 1'b0 || bi.occupancy !== 3'd4) begin bad_cnt++; $display("FAIL full_ready got pr=%b occ=%0d exp pr=0 occ=4", bi.pred_ready, bi.occupancy); end
    step(1'b1, 4'hF, 3'h7, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp_cnt++; if (bi.occupancy !== 3'd4 || bi.upd_valid !== 1'b0) begin bad_cnt++; $display("FAIL full_push_ignored got occ=%0d uv=%b exp occ=4 uv=0", bi.occupancy, bi.upd_valid); end
    step(1'b1, 4'hE, 3'h6, 1'b0, 1'b1, 1'($urandom), 1'b0);
    cmp_cnt++; if (bi.occupancy !== 3'd3 || bi.pred_ready !== 1'b1) begin bad_cnt++; $display("FAIL full_pushpop got occ=%0d pr=%b exp occ=3 pr=1", bi.occupancy, bi.pred_ready); end
    cmp_cnt++; if ({bi.upd_valid, bi.upd_index, bi.upd_bhr, bi.upd_mispredict} !== {exp_uv, exp_ui, exp_ub, exp_um})
      begin bad_cnt++; $display("FAIL full_pushpop_upd got=%h exp=%h", {bi.upd_valid, bi.upd_index, bi.upd_bhr, bi.upd_mispredict}, {exp_uv, exp_ui, exp_ub, exp_um}); end
    step(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp_cnt++; if (bi.occupancy !== 3'd0 || bi.res_ready !== 1'b0) begin bad_cnt++; $display("FAIL full_flush got occ=%0d rr=%b exp occ=0 rr=0", bi.occupancy, bi.res_ready); end
  endtask

  task automatic test_stream();
    int t0, m0, nmiss;
    bit tk, oc;
    t0 = tot; m0 = mis; nmiss = 0;
    for (int i = 0; i < 10; i++) begin
      tk = 1'($urandom); oc = 1'($urandom);
      if (tk != oc) nmiss++;
      step(1'b1, K'($urandom), M'($urandom), tk, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, oc, 1'b0);
      cmp_cnt++; if ({bi.upd_valid, bi.upd_index, bi.upd_bhr, bi.upd_outcome, bi.upd_mispredict} !== {1'b1, exp_ui, exp_ub, oc, 1'(tk != oc)})
        begin bad_cnt++; $display("FAIL stream_upd i=%0d got=%h exp=%h", i, {bi.upd_valid, bi.upd_index, bi.upd_bhr, bi.upd_outcome, bi.upd_mispredict}, {1'b1, exp_ui, exp_ub, oc, 1'(tk != oc)}); end
    end
    cmp_cnt++; if (int'(bi.total_cnt) !== t0 + 10 || int'(bi.miss_cnt) !== m0 + nmiss)
      begin bad_cnt++; $display("FAIL stream_cnt got=%0d/%0d exp=%0d/%0d", bi.total_cnt, bi.miss_cnt, t0 + 10, m0 + nmiss); end
  endtask

  task automatic test_flush();
    int t0, m0;
    for (int i = 0; i < 3; i++) step(1'b1, K'(i + 8), M'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    t0 = tot; m0 = mis;
    step(1'b1, 4'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    cmp_cnt++; if (bi.occupancy !== 3'd0 || bi.upd_valid !== 1'b1 || bi.upd_index !== 4'd8 || bi.upd_mispredict !== 1'b1)
      begin bad_cnt++; $display("FAIL flush_pop got occ=%0d uv=%b ui=%0d um=%b exp occ=0 uv=1 ui=8 um=1", bi.occupancy, bi.upd_valid, bi.upd_index, bi.upd_mispredict); end
    cmp_cnt++; if (int'(bi.miss_cnt) !== m0 + 1 || int'(bi.total_cnt) !== t0 + 1) begin bad_cnt++; $display("FAIL flush_cnt got=%0d/%0d exp=%0d/%0d", bi.total_cnt, bi.miss_cnt, t0 + 1, m0 + 1); end
    for (int i = 0; i < 3; i++) step(1'b1, K'(i), M'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef FLUSH_ON_MISS_EN
    cmp_cnt++; if (bi.occupancy !== 3'd0) begin bad_cnt++; $display("FAIL miss_autoflush got occ=%0d exp=0", bi.occupancy); end
`else
    cmp_cnt++; if (bi.occupancy !== 3'd2) begin bad_cnt++; $display("FAIL miss_noflush got occ=%0d exp=2", bi.occupancy); end
`endif
    step(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      cmp_cnt++; if ({bi.pred_ready, bi.res_ready} !== {1'(mq.size() < TB_DEPTH), 1'(mq.size() > 0)})
        begin bad_cnt++; $display("FAIL rnd_ready c=%0d got=%b%b size=%0d", c, bi.pred_ready, bi.res_ready, mq.size()); end
      step(1'($urandom_range(0, 9) < 6), K'($urandom), M'($urandom), 1'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom_range(0, 19) == 0));
      cmp_cnt++; if ({bi.upd_valid, bi.upd_index, bi.upd_bhr, bi.upd_outcome, bi.upd_mispredict} !== {exp_uv, exp_ui, exp_ub, exp_uo, exp_um})
        begin bad_cnt++; $display("FAIL rnd_upd c=%0d got=%h exp=%h", c, {bi.upd_valid, bi.upd_index, bi.upd_bhr, bi.upd_outcome, bi.upd_mispredict}, {exp_uv, exp_ui, exp_ub, exp_uo, exp_um}); end
      cmp_cnt++; if (int'(bi.occupancy) !== mq.size()) begin bad_cnt++; $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, bi.occupancy, mq.size()); end
      cmp_cnt++; if (int'(bi.total_cnt) !== sat(tot, 65535) || int'(bi.miss_cnt) !== sat(mis, 65535))
        begin bad_cnt++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, bi.total_cnt, bi.miss_cnt, tot, mis); end
      cmp_cnt++; if (int'(bs.total_cnt) !== sat(tot, SMALL_MAX) || int'(bs.miss_cnt) !== sat(mis, SMALL_MAX))
        begin bad_cnt++; $display("FAIL rnd_small_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, bs.total_cnt, bs.miss_cnt, sat(tot, SMALL_MAX), sat(mis, SMALL_MAX)); end
    end
    step(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_saturate();
    step(1'b1, 4'd2, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, K'(i), M'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    cmp_cnt++; if (bs.total_cnt !== 3'd7 || bs.miss_cnt !== 3'd7) begin bad_cnt++; $display("FAIL sat_small got=%0d/%0d exp=7/7", bs.total_cnt, bs.miss_cnt); end
    cmp_cnt++; if (int'(bi.total_cnt) !== tot || int'(bi.miss_cnt) !== mis) begin bad_cnt++; $display("FAIL sat_wide got=%0d/%0d exp=%0d/%0d", bi.total_cnt, bi.miss_cnt, tot, mis); end
    cmp_cnt++; if (bs.upd_valid !== 1'b1 || bs.upd_mispredict !== 1'b1) begin bad_cnt++; $display("FAIL sat_small_upd got uv=%b um=%b exp 1/1", bs.upd_valid, bs.upd_mispredict); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) step(1'b1, K'($urandom), M'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    cmp_cnt++; if (bi.occupancy !== 3'd0 || bi.upd_valid !== 1'b0 || bi.res_ready !== 1'b0 || bi.total_cnt !== 16'd0)
      begin bad_cnt++; $display("FAIL midreset got occ=%0d uv=%b rr=%b tot=%0d exp 0/0/0/0", bi.occupancy, bi.upd_valid, bi.res_ready, bi.total_cnt); end
    model_reset();
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cmp_cnt++; if (bi.upd_valid !== 1'b0 || bi.occupancy !== 3'd0 || bi.total_cnt !== 16'd0)
      begin bad_cnt++; $display("FAIL midreset_after got uv=%b occ=%0d tot=%0d exp 0/0/0", bi.upd_valid, bi.occupancy, bi.total_cnt); end
  endtask

  initial begin
    cmp_cnt = 0;
    bad_cnt = 0;
    drive_idle();
    test_reset();
    test_single();
    test_full();
    test_stream();
    test_flush();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", cmp_cnt, bad_cnt);
    $finish;
  end

endmodule
